fp_align_unit: RTL
==================

# fp_align_unit

Front-end alignment stage of the FP adder and the producer for the normalize/round stage. It accepts two packed IEEE-754 single-precision operands through a valid/ready handshake and unpacks them. It orders the operands by magnitude, then right-shifts the smaller significand iteratively, SHIFT_PER_CYCLE bit positions per clock, to the larger exponent. It delivers the aligned significands, the common exponent, and guard/round/sticky bits through a second valid/ready handshake.

## Interface
- SHIFT_PER_CYCLE, 1: right-shift positions per SHIFT cycle; legal values 1, 2, 4, 8.
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; equals (state==IDLE) && !reset.
- a, b  in  32  packed single-precision operands.
- out_valid  out  1  aligned result valid; equals (state==DONE).
- out_ready  in  1  downstream accepts result.
- big_mant  out  24  larger-magnitude significand, hidden bit at [23].
- small_mant  out  24  aligned smaller significand.
- guard, round, sticky  out  1 each  first, second, and OR of all further bits shifted out of small_mant.
- exp_out  out  8  exponent of the larger operand; 1 for a subnormal.
- big_sign  out  1  sign of the larger operand.
- eff_sub  out  1  a[31]^b[31].
- special  out  1  either operand has exponent 0xFF.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset puts the FSM in IDLE and clears every output register to 0.
- Accept on in_valid && in_ready, which can occur only in IDLE. On that edge the block:
  - unpacks both operands: sign, exponent, and significand {hidden, frac}. The hidden bit is 1 when exp!=0.
  - compares magnitude as {exp, frac}. The larger operand becomes big. On a tie, a is big.
  - loads the small significand into a 26-bit shift register {mant24, G, R} and clears the sticky register.
  - sets remaining = min(exp_big - exp_small, 27).
  - sets the next state:
    - special=1: DONE, with small_mant=0 and G=R=S=0. big_* and exp_out are still loaded.
    - else remaining==0: DONE.
    - else remaining>=27: DONE, with small_mant=0, G=R=0, sticky = OR of the small significand.
    - else: SHIFT.
- SHIFT, each edge:
  - k = min(SHIFT_PER_CYCLE, remaining).
  - Shift the register right by k.
  - OR into sticky every bit leaving the R position.
  - remaining -= k.
  - Go to DONE when remaining reaches 0.
- DONE: all outputs are held stable while out_ready is low. On out_valid && out_ready, go to IDLE. There is no accept in that same cycle.
- Zero operands need no special path: a zero significand shifts to zero with sticky=0.

## Timing
- Counting the accept edge as edge 1, out_valid rises after edge 1 + ceil(d/SHIFT_PER_CYCLE), where d is the diff clamped to 27. Special, d=0, and d>=27 all give out_valid after edge 1.
- Worst case with SHIFT_PER_CYCLE=1: 27 cycles from accept to out_valid.
- Throughput: at most one operation per (latency + 2) cycles. in_ready is low from the accept edge until the cycle after the output handshake.
- Asserting reset mid-SHIFT or mid-DONE aborts the operation immediately. out_valid=0, all outputs are 0, and in_ready=1 on the first cycle after reset deasserts.
- in_valid in a non-IDLE state is ignored. a and b are sampled only on the accept edge.

## Configuration
- DENORMAL_EN defined: an exp==0 operand is subnormal, with hidden bit 0 and effective exponent 1 for both the diff and exp_out.
- DENORMAL_EN undefined: an exp==0 operand is flushed to zero, with significand 0 and exponent 0. Its frac bits never reach sticky.

## Test plan
- a=0x3F800000, b=0x3F800000 -> out_valid after edge 1; big_mant=small_mant=0x800000, exp_out=0x7F, G=R=S=0, eff_sub=0.
- a=0x3F800000, b=0xC0000000 (S=1) -> swap; big_mant=0x800000, small_mant=0x400000, exp_out=0x80, big_sign=1, eff_sub=1, G=R=S=0, out_valid after edge 2.
- a=0x3F800001, b=0x4B000000 (S=1) -> d=23; small_mant=0x000001, G=0, R=0, S=1, exp_out=0x96, out_valid after edge 24. With S=8: after edge 4, identical values.
- a=0x3F800000, b=0x4F800000 -> d=32, clamped; small_mant=0, G=R=0, S=1, exp_out=0x9F, out_valid after edge 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs unchanged, in_ready=0. Separately, pulse reset during SHIFT -> out_valid=0, in_ready=1 after release.
- a=0x00800000, b=0x00000001:
  - With DENORMAL_EN: d=0, big_mant=0x800000, small_mant=0x000001, exp_out=0x01.
  - Without DENORMAL_EN: small_mant=0, S=0.

Source files
------------

// File: rtl/fp_align_unit.sv
// Single-precision FP adder alignment stage: unpacks, orders by magnitude, and right-shifts
// the smaller significand SHIFT_PER_CYCLE bits per clock. Optional macro: DENORMAL_EN.
module fp_align_unit #(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] big_mant,
  output logic [23:0] small_mant,
  output logic        guard,
  output logic        round,
  output logic        sticky,
  output logic [7:0]  exp_out,
  output logic        big_sign,
  output logic        eff_sub,
  output logic        special
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

  stateT       stateReg, stateNext;
  logic [25:0] shiftReg, shiftNext;
  logic        stickyReg, stickyNext;
  logic [4:0]  remainingReg, remainingNext;
  logic [23:0] bigMantReg;
  logic [7:0]  expOutReg;
  logic        bigSignReg, effSubReg, specialReg;

  logic [23:0] mantA, mantB, mantBig, mantSmall;
  logic [7:0]  effExpA, effExpB, effExpBig, effExpSmall;
  logic [8:0]  diff;
  logic        aIsBig, specialIn, overRange, accept;

  // Operand unpacking; exp==0 handling is the only configurable behaviour.
  always_comb begin
`ifdef DENORMAL_EN
    mantA   = {a[30:23] != 8'd0, a[22:0]};
    mantB   = {b[30:23] != 8'd0, b[22:0]};
    effExpA = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    effExpB = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
`else
    mantA   = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    mantB   = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    effExpA = a[30:23];
    effExpB = b[30:23];
`endif
  end

  // {exp, frac} is exactly a[30:0]; ties keep a as the larger operand.
  assign aIsBig      = a[30:0] >= b[30:0];
  assign mantBig     = aIsBig ? mantA : mantB;
  assign mantSmall   = aIsBig ? mantB : mantA;
  assign effExpBig   = aIsBig ? effExpA : effExpB;
  assign effExpSmall = aIsBig ? effExpB : effExpA;
  assign diff        = {1'b0, effExpBig} - {1'b0, effExpSmall};
  assign overRange   = diff >= 9'd27;
  assign specialIn   = (&a[30:23]) | (&b[30:23]);
  assign accept      = in_valid && in_ready;

  // One SHIFT cycle: up to SHIFT_PER_CYCLE single-bit steps, each dropping bit 0 into sticky.
  always_comb begin
    shiftNext     = shiftReg;
    stickyNext    = stickyReg;
    remainingNext = remainingReg;
    for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (remainingNext != 5'd0) begin
        stickyNext    = stickyNext | shiftNext[0];
        shiftNext     = shiftNext >> 1;
        remainingNext = remainingNext - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:
        if (accept)
          stateNext = (specialIn || diff == 9'd0 || overRange) ? DONE : SHIFT;
      SHIFT:
        if (remainingNext == 5'd0) stateNext = DONE;
      DONE:
        if (out_ready) stateNext = IDLE;
      default:
        stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (stateReg == IDLE) && !reset;
    out_valid = (stateReg == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg     <= '0;
      stickyReg    <= 1'b0;
      remainingReg <= '0;
      bigMantReg   <= '0;
      expOutReg    <= '0;
      bigSignReg   <= 1'b0;
      effSubReg    <= 1'b0;
      specialReg   <= 1'b0;
    end else if (accept) begin
      bigMantReg   <= mantBig;
      expOutReg    <= effExpBig;
      bigSignReg   <= aIsBig ? a[31] : b[31];
      effSubReg    <= a[31] ^ b[31];
      specialReg   <= specialIn;
      // Out-of-range shifts skip the SHIFT state: everything lands in sticky at once.
      shiftReg     <= (specialIn || overRange) ? 26'd0 : {mantSmall, 2'b00};
      stickyReg    <= !specialIn && overRange && (|mantSmall);
      remainingReg <= (specialIn || overRange) ? 5'd0 : diff[4:0];
    end else if (stateReg == SHIFT) begin
      shiftReg     <= shiftNext;
      stickyReg    <= stickyNext;
      remainingReg <= remainingNext;
    end
  end

  assign big_mant   = bigMantReg;
  assign small_mant = shiftReg[25:2];
  assign guard      = shiftReg[1];
  assign round      = shiftReg[0];
  assign sticky     = stickyReg;
  assign exp_out    = expOutReg;
  assign big_sign   = bigSignReg;
  assign eff_sub    = effSubReg;
  assign special    = specialReg;

endmodule
